// File: rtl/stopwatch_lap_timer.sv
// BCD M:SS.f up/down stopwatch with run-state FSM, preset load, expiry flash
// and a first-word-fall-through lap-snapshot FIFO.
module stopwatch_lap_timer #(
  parameter int unsigned TICK_DIV    = 10000000,
  parameter int unsigned LAP_DEPTH   = 8,
  parameter int unsigned FLASH_DIV   = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             dir,
  input  logic                             clr,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             lap,
  input  logic                             load,
  input  logic [15:0]                      preset,
  output logic [15:0]                      time_out,
  output logic                             running,
  output logic                             expired,
  output logic                             flash,
  input  logic                             lap_rd,
  output logic [15:0]                      lap_data,
  output logic                             lap_valid,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
  output logic                             lap_ovf
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int unsigned PW = $clog2(LAP_DEPTH);
  localparam int unsigned CW = $clog2(LAP_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_e;

  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] m, s1, s0, f;
    {m, s1, s0, f} = t;
    if (f != 4'd9) f = f + 4'd1;
    else begin
      f = 4'd0;
      if (s0 != 4'd9) s0 = s0 + 4'd1;
      else begin
        s0 = 4'd0;
        if (s1 != 4'd5) s1 = s1 + 4'd1;
        else begin
          s1 = 4'd0;
          m  = m + 4'd1;
        end
      end
    end
    return {m, s1, s0, f};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] m, s1, s0, f;
    {m, s1, s0, f} = t;
    if (f != 4'd0) f = f - 4'd1;
    else begin
      f = 4'd9;
      if (s0 != 4'd0) s0 = s0 - 4'd1;
      else begin
        s0 = 4'd9;
        if (s1 != 4'd0) s1 = s1 - 4'd1;
        else begin
          s1 = 4'd5;
          m  = m - 4'd1;
        end
      end
    end
    return {m, s1, s0, f};
  endfunction

  function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  // Button synchronisers and rising-edge pulses: bit 0 start, 1 stop, 2 lap
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  prev_q;
  logic [2:0]                  synced;
  logic [2:0]                  press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {lap, stop, start}};
      prev_q <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign press  = synced & ~prev_q;

  logic start_p, stop_p, lap_p;
  assign start_p = press[0];
  assign stop_p  = press[1];
  assign lap_p   = press[2];

  state_e          state_q, state_d;
  logic [15:0]     time_q, time_d;
  logic [TW-1:0]   presc_q, presc_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            dir_q, dir_d;
  logic            flash_q, flash_d;
  logic            running_q, expired_q;
  logic            load_acc, tick;
  logic [15:0]     preset_sat;

  assign load_acc   = load && (state_q != RUN);
  assign tick       = (state_q == RUN) && (presc_q == TW'(TICK_DIV - 1));
  assign preset_sat = {sat_digit(preset[15:12], 4'd9), sat_digit(preset[11:8], 4'd5),
                       sat_digit(preset[7:4], 4'd9), sat_digit(preset[3:0], 4'd9)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      time_q    <= '0;
      presc_q   <= '0;
      fcnt_q    <= '0;
      dir_q     <= 1'b0;
      flash_q   <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      presc_q   <= presc_d;
      fcnt_q    <= fcnt_d;
      dir_q     <= dir_d;
      flash_q   <= flash_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == EXPIRED);
    end
  end

  // Next-state: clr > load > stop > start; tick/terminal handling only in RUN
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    flash_d = flash_q;
    fcnt_d  = fcnt_q;
    if (clr) begin
      state_d = IDLE;
      time_d  = '0;
      presc_d = '0;
    end else if (load_acc) begin
      state_d = IDLE;
      time_d  = preset_sat;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!stop_p && start_p) begin
            state_d = RUN;
            dir_d   = dir;
            presc_d = '0;
          end
        end
        RUN: begin
          if (stop_p) state_d = PAUSE;
          else if (!dir_q && (time_q == 16'h0000)) state_d = EXPIRED;
          else if (tick) begin
            presc_d = '0;
            if (!dir_q) time_d = bcd_dec(time_q);
            else if (time_q == 16'h9599) state_d = EXPIRED;
            else time_d = bcd_inc(time_q);
          end else presc_d = presc_q + TW'(1);
        end
        PAUSE: begin
          if (!stop_p && start_p) begin
            state_d = RUN;
            dir_d   = dir;
          end
        end
        default: ;
      endcase
    end
    // Flash starts lit on entry to EXPIRED and toggles every FLASH_DIV cycles
    if (state_d != EXPIRED) begin
      flash_d = 1'b0;
      fcnt_d  = '0;
    end else if (state_q != EXPIRED) begin
      flash_d = 1'b1;
      fcnt_d  = '0;
    end else if (fcnt_q == FW'(FLASH_DIV - 1)) begin
      flash_d = ~flash_q;
      fcnt_d  = '0;
    end else fcnt_d = fcnt_q + FW'(1);
  end

  assign time_out = time_q;
  assign running  = running_q;
  assign expired  = expired_q;
  assign flash    = flash_q;

  // Lap FIFO; a full FIFO still accepts a push when a pop frees a slot that cycle
  logic [15:0]   mem_q [LAP_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push_req, push, pop, full;

  assign full     = (cnt_q == CW'(LAP_DEPTH));
  assign push_req = lap_p && ((state_q == RUN) || (state_q == PAUSE)) && !clr && !load_acc;
  assign pop      = lap_rd && (cnt_q != '0) && !clr;
  assign push     = push_req && (!full || pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop) rd_d = rd_q + PW'(1);
      if (push && !pop) cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
      if (push_req && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < int'(LAP_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (push) mem_q[wr_q] <= time_q;
    end
  end

  assign lap_data  = mem_q[rd_q];
  assign lap_valid = (cnt_q != '0);
  assign lap_count = cnt_q;
  assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Directed bench for stopwatch_lap_timer with small dividers and hand-computed expectations.
module tb_stopwatch_lap_timer;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned LAP_DEPTH   = 4;
  localparam int unsigned FLASH_DIV   = 3;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CW          = $clog2(LAP_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, dir, clr, start, stop, lap, load, lap_rd;
  logic [15:0]   preset;
  logic [15:0]   time_out, lap_data;
  logic          running, expired, flash, lap_valid, lap_ovf;
  logic [CW-1:0] lap_count;

  int errors = 0;
  int checks = 0;

  stopwatch_lap_timer #(
    .TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH),
    .FLASH_DIV(FLASH_DIV), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .dir(dir), .clr(clr), .start(start), .stop(stop),
    .lap(lap), .load(load), .preset(preset), .time_out(time_out),
    .running(running), .expired(expired), .flash(flash), .lap_rd(lap_rd),
    .lap_data(lap_data), .lap_valid(lap_valid), .lap_count(lap_count),
    .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a raw button high for three cycles; its event has acted on return
  task automatic press(input int which);
    case (which)
      0: start = 1'b1;
      1: stop  = 1'b1;
      default: lap = 1'b1;
    endcase
    cyc(3);
    start = 1'b0;
    stop  = 1'b0;
    lap   = 1'b0;
  endtask

  task automatic pulse_load(input logic [15:0] p);
    preset = p;
    load   = 1'b1;
    cyc(1);
    load   = 1'b0;
  endtask

  logic fseq [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b0; dir = 1'b0; clr = 1'b0; start = 1'b0; stop = 1'b0;
    lap = 1'b0; load = 1'b0; lap_rd = 1'b0; preset = '0;
    cyc(2);
    check("rst_time", time_out, 16'h0000);
    check("rst_running", 16'(running), 16'd0);
    check("rst_expired", 16'(expired), 16'd0);
    check("rst_flash", 16'(flash), 16'd0);
    check("rst_lap_count", 16'(lap_count), 16'd0);
    check("rst_lap_valid", 16'(lap_valid), 16'd0);
    check("rst_lap_data", lap_data, 16'h0000);
    rst = 1'b1;
    cyc(1);

    // Count up from zero
    dir = 1'b1;
    press(0);
    check("up_running", 16'(running), 16'd1);
    check("up_t0", time_out, 16'h0000);
    cyc(4);
    check("up_t1", time_out, 16'h0001);
    cyc(36);
    check("up_t10", time_out, 16'h0010);

    // Five laps 8 cycles apart; the fifth overflows
    press(2); cyc(5);
    press(2); cyc(5);
    press(2); cyc(5);
    press(2); cyc(5);
    press(2);
    check("lap_count_full", 16'(lap_count), 16'd4);
    check("lap_ovf_set", 16'(lap_ovf), 16'd1);
    check("lap_valid_full", 16'(lap_valid), 16'd1);
    check("lap_run_time", time_out, 16'h0018);
    check("lap_pop0", lap_data, 16'h0010);
    lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
    check("lap_pop1", lap_data, 16'h0012);
    lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
    check("lap_pop2", lap_data, 16'h0014);
    lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
    check("lap_pop3", lap_data, 16'h0016);
    lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
    check("lap_valid_empty", 16'(lap_valid), 16'd0);
    check("lap_count_empty", 16'(lap_count), 16'd0);
    clr = 1'b1; cyc(1); clr = 1'b0;
    check("clr_ovf", 16'(lap_ovf), 16'd0);
    check("clr_time", time_out, 16'h0000);
    check("clr_running", 16'(running), 16'd0);

    // Up-count expiry at 9:59.9 with flash pattern
    pulse_load(16'h9598);
    check("load_9598", time_out, 16'h9598);
    dir = 1'b1;
    press(0);
    cyc(4);
    check("up_9599", time_out, 16'h9599);
    cyc(4);
    check("up_exp_expired", 16'(expired), 16'd1);
    check("up_exp_running", 16'(running), 16'd0);
    check("up_exp_hold", time_out, 16'h9599);
    check("flash_0", 16'(flash), 16'(fseq[0]));
    for (int i = 1; i < 7; i++) begin
      cyc(1);
      check($sformatf("flash_%0d", i), 16'(flash), 16'(fseq[i]));
    end
    press(0);
    check("exp_start_ignored", 16'(expired), 16'd1);

    // Countdown from 1.0 s; dir toggle mid-run has no effect
    pulse_load(16'h0010);
    check("load_exit_exp", 16'(expired), 16'd0);
    check("load_exit_flash", 16'(flash), 16'd0);
    dir = 1'b0;
    press(0);
    cyc(4);
    check("dn_0009", time_out, 16'h0009);
    dir = 1'b1;
    cyc(36);
    check("dn_0000", time_out, 16'h0000);
    check("dn_0000_running", 16'(running), 16'd1);
    cyc(1);
    check("dn_expired", 16'(expired), 16'd1);

    // Preset digit saturation, then countdown start at zero
    pulse_load(16'h97A9);
    check("preset_sat", time_out, 16'h9599);
    pulse_load(16'h0000);
    dir = 1'b0;
    press(0);
    check("zero_start_running", 16'(running), 16'd1);
    cyc(1);
    check("zero_start_expired", 16'(expired), 16'd1);

    // Pause, simultaneous start+stop, resume, load ignored in RUN
    clr = 1'b1; cyc(1); clr = 1'b0;
    dir = 1'b1;
    press(0);
    cyc(6);
    check("p_t1", time_out, 16'h0001);
    press(1);
    check("pause_running", 16'(running), 16'd0);
    check("pause_time", time_out, 16'h0002);
    cyc(3);
    start = 1'b1; stop = 1'b1;
    cyc(3);
    check("startstop_pause", 16'(running), 16'd0);
    start = 1'b0; stop = 1'b0;
    cyc(6);
    check("startstop_hold_running", 16'(running), 16'd0);
    check("startstop_hold_time", time_out, 16'h0002);
    press(0);
    check("resume_running", 16'(running), 16'd1);
    pulse_load(16'h5555);
    check("load_in_run_time", time_out, 16'h0002);
    check("load_in_run_running", 16'(running), 16'd1);
    cyc(3);
    check("resume_t3", time_out, 16'h0003);

    // Asynchronous reset between clock edges
    press(2);
    check("pre_rst_lap_count", 16'(lap_count), 16'd1);
    #2 rst = 1'b0;
    #1;
    check("async_time", time_out, 16'h0000);
    check("async_running", 16'(running), 16'd0);
    check("async_lap_count", 16'(lap_count), 16'd0);
    check("async_lap_valid", 16'(lap_valid), 16'd0);
    cyc(1);
    rst = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
